// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch sequencer. It produces the fetch address,
// registers each fetched instruction with its address, handles stall, jump,
// branch, halt and fault, and wraps sequential fetch within IMEM_BYTES.
// Optional feature: define FETCH_PERF_COUNTER_EN to add a saturating
// fetch_count output that counts instructions delivered with instr_valid=1.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,          // active-low, asynchronous
  input  logic        start,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic [31:0] read_addr,
  input  logic [31:0] instruction,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic        fault
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam logic [31:0] ADDR_MASK  = 32'(IMEM_BYTES - 1);
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_HALT  = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pcout_reg, pcout_next;
  logic        valid_reg, valid_next;
  logic        fault_reg, fault_next;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        target_bad;

  // Select the winning redirect (jump beats branch) and check it is a legal word address.
  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
    target_bad      = (redirect_target[1:0] != 2'b00) || (redirect_target >= IMEM_LIMIT);
  end

  // Next-state and datapath decisions; priority in RUN is halt > stall > redirect > sequential.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    pcout_next = pcout_reg;
    valid_next = 1'b0;
    fault_next = fault_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          pc_next    = RESET_PC;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          // The instruction on the bus this cycle is dropped; PC freezes.
          state_next = S_HALT;
        end else if (stall) begin
          // Hold everything; redirects wait for the requester to re-present them.
          state_next = S_RUN;
        end else if (redirect && target_bad) begin
          // Faulting cycle: nothing is delivered and PC is left where it was.
          state_next = S_FAULT;
          fault_next = 1'b1;
        end else begin
          valid_next = 1'b1;
          instr_next = instruction;
          pcout_next = pc_reg;
          pc_next    = redirect ? redirect_target : ((pc_reg + 32'd4) & ADDR_MASK);
        end
      end
      S_HALT: begin
        if (start) begin
          state_next = S_RUN;
          pc_next    = RESET_PC;
        end
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'd0;
      pcout_reg <= 32'd0;
      valid_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      pcout_reg <= pcout_next;
      valid_reg <= valid_next;
      fault_reg <= fault_next;
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] count_reg;

  // Count every delivered instruction, saturating at all ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= 32'd0;
    end else if (valid_next && (count_reg != 32'hFFFF_FFFF)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign fetch_count = count_reg;
`endif

  // IDLE always presents the reset address; elsewhere the PC drives memory.
  assign read_addr   = (state_reg == S_IDLE) ? RESET_PC : pc_reg;
  assign instr_out   = instr_reg;
  assign pc_out      = pcout_reg;
  assign instr_valid = valid_reg;
  assign state       = state_reg;
  assign fault       = fault_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. Memory model: word n holds value n.
// A second instance with RESET_PC=0x3F8 exercises address wrap-around.
module tb_fetch_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, start2, stall, jump, branch_taken, halt_req;
  logic [31:0] jump_target, branch_target;

  logic [31:0] read_addr, instruction, instr_out, pc_out;
  logic        instr_valid, fault;
  logic [1:0]  state;
  logic [31:0] read_addr2, instruction2, instr_out2, pc_out2;
  logic        instr_valid2, fault2;
  logic [1:0]  state2;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count, fetch_count2;
`endif

  assign instruction  = read_addr >> 2;
  assign instruction2 = read_addr2 >> 2;

  fetch_sequencer #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .read_addr(read_addr), .instruction(instruction),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .state(state), .fault(fault)
`ifdef FETCH_PERF_COUNTER_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'h3F8), .IMEM_BYTES(1024)) dut_wrap (
    .clock(clock), .reset(reset), .start(start2), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .read_addr(read_addr2), .instruction(instruction2),
    .instr_out(instr_out2), .pc_out(pc_out2), .instr_valid(instr_valid2),
    .state(state2), .fault(fault2)
`ifdef FETCH_PERF_COUNTER_EN
    , .fetch_count(fetch_count2)
`endif
  );

  typedef struct {
    logic        sel;
    logic        v;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_count = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Push the expected output of the coming edge, clock, then pop and compare.
  task automatic expect_cycle(input logic sel, input logic v, input logic [31:0] pc);
    exp_t e;
    e.sel = sel;
    e.v   = v;
    e.pc  = pc;
    sb.push_back(e);
    if (!sel && v) exp_count++;
    tick();
    e = sb.pop_front();
    if (!e.sel) begin
      check_val("instr_valid", {31'd0, instr_valid}, {31'd0, e.v});
      if (e.v) begin
        check_val("pc_out", pc_out, e.pc);
        check_val("instr_out", instr_out, e.pc >> 2);
      end
    end else begin
      check_val("wrap_valid", {31'd0, instr_valid2}, {31'd0, e.v});
      if (e.v) begin
        check_val("wrap_pc_out", pc_out2, e.pc);
        check_val("wrap_instr_out", instr_out2, e.pc >> 2);
      end
    end
  endtask

  task automatic check_count(input string tag);
`ifdef FETCH_PERF_COUNTER_EN
    check_val(tag, fetch_count, exp_count);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Assert reset between edges, check the asynchronous clear, then release.
  task automatic apply_reset();
    start = 0; start2 = 0; stall = 0; jump = 0; branch_taken = 0; halt_req = 0;
    jump_target = 0; branch_target = 0;
    reset = 1'b0;
    #2;
    check_val("rst_state", {30'd0, state}, 32'd0);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_pc_out", pc_out, 32'd0);
    check_val("rst_instr_out", instr_out, 32'd0);
    check_val("rst_fault", {31'd0, fault}, 32'd0);
    check_val("rst_read_addr", read_addr, 32'd0);
    sb.delete();
    exp_count = 0;
    check_count("rst_count");
    tick();
    reset = 1'b1;
  endtask

  task automatic start_run();
    start = 1;
    expect_cycle(0, 0, 0);
    start = 0;
    check_val("start_state", {30'd0, state}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    start = 0; start2 = 0; stall = 0; jump = 0; branch_taken = 0; halt_req = 0;
    jump_target = 0; branch_target = 0;
    tick();
    apply_reset();
    // Reset release alone must not start fetching.
    expect_cycle(0, 0, 0);
    check_val("idle_after_rst", {30'd0, state}, 32'd0);

    // Sequential fetch, then jump+branch together at 0x10.
    start_run();
    for (int i = 0; i < 4; i++) expect_cycle(0, 1, 32'(4 * i));
    check_count("count_seq");
    jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80;
    expect_cycle(0, 1, 32'h10);
    jump = 0; branch_taken = 0;
    expect_cycle(0, 1, 32'h40);
    expect_cycle(0, 1, 32'h44);

    // Stall three cycles with a jump held.
    stall = 1; jump = 1; jump_target = 32'h100;
    for (int i = 0; i < 3; i++) begin
      expect_cycle(0, 0, 0);
      check_val("stall_read_addr", read_addr, 32'h48);
      check_val("stall_pc_out", pc_out, 32'h44);
    end
    stall = 0;
    expect_cycle(0, 1, 32'h48);
    jump = 0;
    expect_cycle(0, 1, 32'h100);
    expect_cycle(0, 1, 32'h104);
    check_count("count_redirect");

    // Reset in the middle of RUN.
    apply_reset();
    start_run();
    expect_cycle(0, 1, 32'h0);

    // Misaligned jump faults; start is ignored afterwards.
    apply_reset();
    start_run();
    expect_cycle(0, 1, 32'h0);
    expect_cycle(0, 1, 32'h4);
    jump = 1; jump_target = 32'h42;
    expect_cycle(0, 0, 0);
    jump = 0;
    check_val("fault_state", {30'd0, state}, 32'd3);
    check_val("fault_flag", {31'd0, fault}, 32'd1);
    check_val("fault_read_addr", read_addr, 32'h8);
    start = 1;
    expect_cycle(0, 0, 0);
    expect_cycle(0, 0, 0);
    start = 0;
    check_val("fault_sticky", {30'd0, state}, 32'd3);
    check_count("count_fault");

    // Out-of-range branch faults too.
    apply_reset();
    start_run();
    branch_taken = 1; branch_target = 32'h400;
    expect_cycle(0, 0, 0);
    branch_taken = 0;
    check_val("range_state", {30'd0, state}, 32'd3);
    check_val("range_fault", {31'd0, fault}, 32'd1);
    check_val("range_read_addr", read_addr, 32'h0);

    // Halt at 0x20, inputs ignored in HALT, start resumes at RESET_PC.
    apply_reset();
    start_run();
    for (int i = 0; i < 8; i++) expect_cycle(0, 1, 32'(4 * i));
    halt_req = 1;
    expect_cycle(0, 0, 0);
    halt_req = 0;
    check_val("halt_state", {30'd0, state}, 32'd2);
    jump = 1; jump_target = 32'h40;
    expect_cycle(0, 0, 0);
    expect_cycle(0, 0, 0);
    jump = 0;
    check_val("halt_read_addr", read_addr, 32'h20);
    check_val("halt_hold", {30'd0, state}, 32'd2);
    check_count("count_halt");
    start = 1;
    expect_cycle(0, 0, 0);
    start = 0;
    check_val("resume_state", {30'd0, state}, 32'd1);
    expect_cycle(0, 1, 32'h0);
    expect_cycle(0, 1, 32'h4);

    // Ten fetches then halt; count must read 10 and hold.
    apply_reset();
    start_run();
    for (int i = 0; i < 10; i++) expect_cycle(0, 1, 32'(4 * i));
    halt_req = 1;
    expect_cycle(0, 0, 0);
    halt_req = 0;
    for (int i = 0; i < 3; i++) expect_cycle(0, 0, 0);
`ifdef FETCH_PERF_COUNTER_EN
    check_val("count_ten", fetch_count, 32'd10);
`endif

    // Wrap-around on the RESET_PC=0x3F8 instance.
    apply_reset();
    start2 = 1;
    expect_cycle(1, 0, 0);
    start2 = 0;
    expect_cycle(1, 1, 32'h3F8);
    expect_cycle(1, 1, 32'h3FC);
    expect_cycle(1, 1, 32'h000);
    expect_cycle(1, 1, 32'h004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after start; SHALL be word-aligned.
REQ-002 Parameter IMEM_BYTES, default 1024: instruction memory size in bytes; SHALL be a power of two and at least 8.
REQ-003 clock  in  1: single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  in  1: begin fetching at RESET_PC; sampled in IDLE or HALT.
REQ-006 stall  in  1: hold PC and fetch output for this cycle.
REQ-007 jump  in  1; jump_target  in  32: unconditional redirect request and its byte address.
REQ-008 branch_taken  in  1; branch_target  in  32: taken-branch redirect request and its byte address.
REQ-009 halt_req  in  1: stop fetching.
REQ-010 read_addr  out  32: byte address driven to instruction memory, which returns combinationally.
REQ-011 instruction  in  32: instruction memory read data for read_addr.
REQ-012 instr_out  out  32; pc_out  out  32; instr_valid  out  1: registered fetched instruction, its address, and its qualifier.
REQ-013 state  out  2: IDLE=00, RUN=01, HALT=10, FAULT=11.
REQ-014 fault  out  1: sticky misaligned or out-of-range redirect indication.
REQ-015 fetch_count  out  32: present only when FETCH_PERF_COUNTER_EN is defined.

Function
REQ-016 IDLE: read_addr SHALL equal RESET_PC and instr_valid SHALL be 0; start=1 SHALL move to RUN with PC=RESET_PC.
REQ-017 RUN, stall=0: instr_out<=instruction, pc_out<=read_addr, instr_valid<=1; fetch-to-output latency SHALL be 1 cycle.
REQ-018 RUN, next PC priority: halt_req > stall > jump > branch_taken > sequential PC+4.
REQ-019 stall=1 in RUN: PC, instr_out and pc_out SHALL hold, instr_valid<=0, and jump/branch SHALL be ignored; requesters hold redirects until stall drops.
REQ-020 Sequential increment SHALL wrap: next PC = (PC+4) mod IMEM_BYTES, so IMEM_BYTES-4 is followed by 0.
REQ-021 A redirect SHALL affect only the next PC; the instruction fetched in the redirect cycle SHALL still be output with instr_valid=1.
REQ-022 Redirect target with bits[1:0]!=0 or value >= IMEM_BYTES: enter FAULT, fault<=1, instr_valid<=0, PC unchanged; the faulting instruction SHALL NOT be output.
REQ-023 halt_req=1 in RUN: enter HALT next edge, instr_valid<=0; PC and read_addr SHALL freeze.
REQ-024 HALT: start=1 SHALL restart in RUN at RESET_PC; other inputs SHALL be ignored.
REQ-025 FAULT SHALL be exited only by reset; start SHALL be ignored; read_addr SHALL hold.
REQ-026 start in RUN SHALL be ignored.

Reset
REQ-027 reset=0 SHALL asynchronously force state=IDLE, PC=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, fault=0, and fetch_count=0 when present.
REQ-028 Reset asserted mid-RUN SHALL discard any in-flight fetch; the first valid output after reset SHALL be RESET_PC.
REQ-029 Reset deassertion SHALL NOT start fetching; an explicit start is required.

Configuration
REQ-030 FETCH_PERF_COUNTER_EN defined: fetch_count SHALL increment on every cycle where instr_valid is loaded with 1, saturate at 32'hFFFF_FFFF, and hold in HALT and FAULT.
REQ-031 FETCH_PERF_COUNTER_EN undefined: the fetch_count port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Sequential fetch: reset, then start with memory word n = n. Required: instr_out 0,1,2,... with pc_out 0,4,8,... and instr_valid=1 every cycle from the second edge.
REQ-033 Wrap-around: with IMEM_BYTES=1024, run from RESET_PC=32'h3F8. Required: pc_out sequence 3F8, 3FC, 000, 004.
REQ-034 Redirect: at PC=0x10, assert jump to 0x40 and branch to 0x80 together for 1 cycle. Required: pc_out 0x10 then 0x40; the branch is ignored.
REQ-035 Stall: assert stall for 3 cycles with jump held. Required: instr_valid=0 for 3 cycles, PC held, and the jump taken on the first unstalled cycle.
REQ-036 Fault and halt: jump to 0x42. Required: state=11, fault=1, start ignored, recovery only by reset. Separately, halt_req at PC=0x20 gives state=10, and start resumes at RESET_PC.
REQ-037 Counter (macro defined): 10 unstalled fetches then halt. Required: fetch_count=10, and it stays 10 while in HALT.
